seq_trojan_gen: RTL and testbench
=================================

// Module: seq_trojan_gen
// PURPOSE
//  Parametrised sequential-trigger Trojan benchmark for detection experiments.
//  - Datapath: a log-range encoder registered each cycle.
//  - Trigger: a counter of edges on one selected input bit.
//  - Payload: once the count is reached, the registered value is replaced by a stored snapshot.
//  - Exposes the compare flag plus trigger/state observability for the detection harness.
// PARAMETERS
//  IN_W        10  data input width
//  ENC_W       4   encoder output width; must satisfy 2**ENC_W > IN_W-1
//  TRIG_BIT    0   index of i[] used as trigger source
//  TRIG_EDGE   0   0 = count falling edges, 1 = count rising edges
//  CNT_W       2   edge-counter width
//  TRIG_COUNT  2   count value that fires payload; must be < 2**CNT_W
//  MODE        0   0 = level/wrap (classic), 1 = one-shot with lock
//  PAYLOAD_LEN 3   MODE=1 only: cycles payload stays active (>=1)
// PORTS
//  c          in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  i          in   IN_W   data input
//  cap        in   1      1: snapshot enc(i) into memory register
//  q          out  ENC_W  pipeline register
//  mem        out  ENC_W  memory (snapshot) register
//  res        out  1      1 when q == mem (combinational)
//  trig       out  1      payload active (combinational from state)
//  trig_cnt   out  CNT_W  edge counter value
// BEHAVIOUR
//  - Reset (async, immediate): q=0, mem=0, cnt=0, state=IDLE, trig=0, res=1.
//    Edge-detect flop prev resets to TRIG_EDGE?1:0, so there is no spurious edge at reset release.
//  - Encoder enc(x), combinational:
//    - x==0 -> 0.
//    - Otherwise p = index of MSB set; enc = (p<2) ? 1 : p.
//    - Examples: 1..3->1, 4..7->2, 8..15->3, 512..1023->9.
//  - Edge detect: cur=i[TRIG_BIT]; edge = TRIG_EDGE ? (cur&~prev) : (~cur&prev); prev<=cur each cycle.
//  - Datapath, every posedge:
//    - q <= trig ? mem : enc(i); one-cycle latency.
//    - if cap: mem <= enc(i).
//    - When cap and trig occur in the same cycle, q takes the old mem; mem updates.
//  - MODE=0:
//    - On edge: cnt <= cnt+1 (wraps mod 2**CNT_W).
//    - trig = (cnt==TRIG_COUNT); payload repeats every 2**CNT_W edges.
//  - MODE=1 FSM, states IDLE/FIRE/LOCK:
//    - IDLE: on edge, cnt+1. If the new cnt==TRIG_COUNT -> FIRE and load plen=PAYLOAD_LEN-1.
//    - FIRE: trig=1. If plen==0 -> LOCK, else plen-1. Edges are ignored; cnt holds.
//    - LOCK: trig=0 and all edges are ignored until rst.
//  - res = &(~(q ^ mem)), combinational, no registering.
//  - Reset asserted mid-FIRE aborts the payload immediately; the next trigger needs the full TRIG_COUNT again.
//  - An edge in the same cycle as rst deassertion is not counted.
// STRUCTURE
//  - Package seq_trojan_pkg:
//    - trig_state_t {IDLE, FIRE, LOCK}
//    - function enc_log(x) used by both RTL and model
//    - MODE_LEVEL/MODE_ONESHOT constants
//  - Sub-module seq_trojan_trig: edge detect, counter, FSM, trig output.
//  - Top: encoder, q/mem registers, mux, compare.
// TESTING  (defaults unless stated; mem=0 initially)
//  1. i = 0,1,3,4,8,512,1023, no edges on i[0] (i[0] held constant per pair)
//     -> q next cycle = 0,1,1,2,3,9,9; res=1 only when q==0.
//  2. cap=1 with i=64 -> mem=6. Then i=64 -> res=1. Then i=6 -> q=2, res=0.
//  3. MODE=0, mem=6, i[0] toggled 1->0 twice
//     -> trig=1 and trig_cnt=2 after the 2nd fall; q=6 for any i; res=1.
//     -> 3rd fall: trig=0. 6th fall: trig=1 again (wrap).
//  4. MODE=1, PAYLOAD_LEN=3, mem=6
//     -> trig high exactly 3 cycles after the 2nd fall, q=6 on those cycles.
//     -> further 5 edges: trig stays 0 until rst.
//  5. rst pulsed mid-FIRE, asynchronously between clocks
//     -> q=0, mem=0, trig=0, trig_cnt=0, res=1 before the next posedge.
//  6. TRIG_EDGE=1, i[0]=1 through reset release -> trig_cnt stays 0; two 0->1 edges -> trig=1.

Source files
------------

// File: rtl/seq_trojan_pkg.sv
// Shared types and helpers for the sequential-trigger Trojan benchmark.
// Used by the RTL and by the reference expectations in the bench.
package seq_trojan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    LOCK = 2'd2
  } trig_state_t;

  localparam int MODE_LEVEL   = 0;
  localparam int MODE_ONESHOT = 1;

  // Log-range code: 0 stays 0, values 1..3 share code 1, otherwise MSB index.
  function automatic int unsigned enc_log(input logic [31:0] x);
    int unsigned p;
    p = 0;
    for (int k = 0; k < 32; k++) begin
      if (x[k]) p = k;
    end
    if (x == '0) return 0;
    return (p < 2) ? 1 : p;
  endfunction

endpackage

// File: rtl/seq_trojan_trig.sv
// Trigger path: edge detector on one input bit, edge counter and
// the one-shot FIRE/LOCK sequencer that drives the payload enable.
module seq_trojan_trig
  import seq_trojan_pkg::*;
#(
  parameter int TRIG_EDGE   = 0,
  parameter int CNT_W       = 2,
  parameter int TRIG_COUNT  = 2,
  parameter int MODE        = 0,
  parameter int PAYLOAD_LEN = 3
) (
  input  logic             c,
  input  logic             rst,
  input  logic             i_src,
  output logic             o_trig,
  output logic [CNT_W-1:0] o_cnt
);

  localparam int PL_W =
    (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
  localparam logic [CNT_W-1:0] TC = CNT_W'(TRIG_COUNT);
  localparam logic [PL_W-1:0] PL0 = PL_W'(PAYLOAD_LEN - 1);
  // Reset value matches the idle level, so release never looks like an edge.
  localparam logic PREV_RST = (TRIG_EDGE != 0);

  trig_state_t      r_state;
  trig_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [PL_W-1:0]  r_plen;
  logic [PL_W-1:0]  w_plen_nxt;
  logic             r_prev;
  logic             w_edge;

  assign w_edge = (TRIG_EDGE != 0)
                ? (i_src & ~r_prev)
                : (~i_src & r_prev);
  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_plen  <= '0;
      r_prev  <= PREV_RST;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_plen  <= w_plen_nxt;
      r_prev  <= i_src;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_plen_nxt  = r_plen;
    if (MODE == MODE_LEVEL) begin
      if (w_edge) w_cnt_nxt = w_cnt_inc;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_edge) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == TC) begin
              w_state_nxt = FIRE;
              w_plen_nxt  = PL0;
            end
          end
        end
        FIRE: begin
          if (r_plen == '0) w_state_nxt = LOCK;
          else w_plen_nxt = r_plen - 1'b1;
        end
        LOCK: w_state_nxt = LOCK;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    o_trig = 1'b0;
    if (MODE == MODE_LEVEL) o_trig = (r_cnt == TC);
    else o_trig = (r_state == FIRE);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_trojan_gen.sv
// Sequential-trigger Trojan benchmark: log encoder pipeline whose output
// is swapped for a stored snapshot while the trigger is active.
module seq_trojan_gen
  import seq_trojan_pkg::*;
#(
  parameter int IN_W        = 10,
  parameter int ENC_W       = 4,
  parameter int TRIG_BIT    = 0,
  parameter int TRIG_EDGE   = 0,
  parameter int CNT_W       = 2,
  parameter int TRIG_COUNT  = 2,
  parameter int MODE        = 0,
  parameter int PAYLOAD_LEN = 3
) (
  input  logic             c,
  input  logic             rst,
  input  logic [IN_W-1:0]  i,
  input  logic             cap,
  output logic [ENC_W-1:0] q,
  output logic [ENC_W-1:0] mem,
  output logic             res,
  output logic             trig,
  output logic [CNT_W-1:0] trig_cnt
);

  logic [ENC_W-1:0] w_enc;

  assign w_enc = ENC_W'(enc_log(32'(i)));

  seq_trojan_trig #(
    .TRIG_EDGE   (TRIG_EDGE),
    .CNT_W       (CNT_W),
    .TRIG_COUNT  (TRIG_COUNT),
    .MODE        (MODE),
    .PAYLOAD_LEN (PAYLOAD_LEN)
  ) u_trig (
    .c      (c),
    .rst    (rst),
    .i_src  (i[TRIG_BIT]),
    .o_trig (trig),
    .o_cnt  (trig_cnt)
  );

  // On a cap/trig collision q sees the pre-update snapshot.
  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      q   <= '0;
      mem <= '0;
    end else begin
      q <= trig ? mem : w_enc;
      if (cap) mem <= w_enc;
    end
  end

  assign res = &(~(q ^ mem));

endmodule

// File: tb/tb_seq_trojan_gen.sv
// Directed bench: level mode, one-shot mode and rising-edge trigger
// instances driven side by side with hand-computed expectations.
module tb_seq_trojan_gen;

  logic       c;
  logic       rst;
  logic       rst2;
  logic [9:0] i;
  logic [9:0] i2;
  logic       cap;

  logic [3:0] q0, mem0, q1, mem1, q2, mem2;
  logic       res0, res1, res2;
  logic       trig0, trig1, trig2;
  logic [1:0] cnt0, cnt1, cnt2;

  int checks;
  int errors;

  seq_trojan_gen #(.MODE(0)) u0 (
    .c(c), .rst(rst), .i(i), .cap(cap),
    .q(q0), .mem(mem0), .res(res0),
    .trig(trig0), .trig_cnt(cnt0)
  );

  seq_trojan_gen #(.MODE(1), .PAYLOAD_LEN(3)) u1 (
    .c(c), .rst(rst), .i(i), .cap(cap),
    .q(q1), .mem(mem1), .res(res1),
    .trig(trig1), .trig_cnt(cnt1)
  );

  seq_trojan_gen #(.TRIG_EDGE(1)) u2 (
    .c(c), .rst(rst2), .i(i2), .cap(1'b0),
    .q(q2), .mem(mem2), .res(res2),
    .trig(trig2), .trig_cnt(cnt2)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge c);
    #1;
  endtask

  task automatic reset01;
    rst = 1'b1;
    #1;
    check("rst_q0", 32'(q0), 0);
    check("rst_mem1", 32'(mem1), 0);
    rst = 1'b0;
  endtask

  task automatic capture64;
    cap = 1'b1;
    i   = 10'd64;
    step();
    cap = 1'b0;
    check("cap_mem0", 32'(mem0), 6);
    check("cap_mem1", 32'(mem1), 6);
  endtask

  task automatic fall;
    i = 10'd1;
    step();
    i = 10'd0;
    step();
  endtask

  int vin  [7] = '{0, 4, 8, 512, 1, 3, 1023};
  int vexp [7] = '{0, 2, 3, 9, 1, 1, 9};

  initial begin
    checks = 0;
    errors = 0;
    rst  = 1'b1;
    rst2 = 1'b1;
    i    = '0;
    i2   = 10'd1;
    cap  = 1'b0;
    #2;
    check("rst_q", 32'(q0), 0);
    check("rst_mem", 32'(mem0), 0);
    check("rst_res", 32'(res0), 1);
    check("rst_trig", 32'(trig1), 0);
    check("rst_cnt", 32'(cnt0), 0);
    check("rst_res2", 32'(res2), 1);
    step();
    rst  = 1'b0;
    rst2 = 1'b0;

    // encoder sweep; only rising edges on i[0]
    for (int k = 0; k < 7; k++) begin
      i = 10'(vin[k]);
      step();
      check("enc_q", 32'(q0), 32'(vexp[k]));
      check("enc_res", 32'(res0), (vexp[k] == 0) ? 1 : 0);
    end
    check("enc_cnt", 32'(cnt0), 0);

    capture64();
    check("cap_q", 32'(q0), 6);
    check("cap_res", 32'(res0), 1);
    i = 10'd64;
    step();
    check("eq_res", 32'(res0), 1);
    i = 10'd6;
    step();
    check("ne_q", 32'(q0), 2);
    check("ne_res", 32'(res0), 0);

    reset01();
    capture64();

    fall();
    check("f1_cnt", 32'(cnt0), 1);
    check("f1_trig", 32'(trig0), 0);
    fall();
    check("f2_trig0", 32'(trig0), 1);
    check("f2_cnt0", 32'(cnt0), 2);
    check("f2_trig1", 32'(trig1), 1);
    check("f2_cnt1", 32'(cnt1), 2);

    i = 10'd512;
    step();
    check("pa_q0", 32'(q0), 6);
    check("pa_res0", 32'(res0), 1);
    check("pa_q1", 32'(q1), 6);
    check("pa_trig1", 32'(trig1), 1);
    step();
    check("pb_q1", 32'(q1), 6);
    check("pb_trig1", 32'(trig1), 1);
    step();
    check("pc_q1", 32'(q1), 6);
    check("pc_trig1", 32'(trig1), 0);
    check("pc_q0", 32'(q0), 6);
    step();
    check("pd_q1", 32'(q1), 9);

    i = 10'd513;
    step();
    i = 10'd512;
    step();
    check("f3_trig0", 32'(trig0), 0);
    check("f3_cnt0", 32'(cnt0), 3);
    for (int k = 0; k < 3; k++) begin
      i = 10'd513;
      step();
      i = 10'd512;
      step();
      check("lock_trig1", 32'(trig1), 0);
      check("lock_cnt1", 32'(cnt1), 2);
    end
    check("f6_trig0", 32'(trig0), 1);
    check("f6_cnt0", 32'(cnt0), 2);

    // async reset in the middle of a one-shot payload
    reset01();
    capture64();
    fall();
    fall();
    i = 10'd512;
    step();
    check("mf_trig1", 32'(trig1), 1);
    #3;
    rst = 1'b1;
    #1;
    check("ar_q", 32'(q1), 0);
    check("ar_mem", 32'(mem1), 0);
    check("ar_trig", 32'(trig1), 0);
    check("ar_cnt", 32'(cnt1), 0);
    check("ar_res", 32'(res1), 1);
    rst = 1'b0;
    fall();
    check("ar_f1_cnt", 32'(cnt1), 1);
    check("ar_f1_trig", 32'(trig1), 0);

    // rising-edge instance, i2[0] was high through reset release
    check("re_cnt0", 32'(cnt2), 0);
    i2 = 10'd0;
    step();
    check("re_low_cnt", 32'(cnt2), 0);
    i2 = 10'd1;
    step();
    check("re_r1_cnt", 32'(cnt2), 1);
    i2 = 10'd0;
    step();
    i2 = 10'd1;
    step();
    check("re_r2_cnt", 32'(cnt2), 2);
    check("re_r2_trig", 32'(trig2), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
